// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter between icache and dcache: grants the bus, tracks which
// cache owns each outstanding memory tag, and steers returning data to that owner.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16,
  parameter int XLEN         = 32,
  parameter int DATA_W       = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        Icache2arb_command,
  input  logic [XLEN-1:0]   Icache2arb_addr,
  input  logic [1:0]        Dcache2arb_command,
  input  logic [XLEN-1:0]   Dcache2arb_addr,
  input  logic [DATA_W-1:0] Dcache2arb_data,
  input  logic [3:0]        mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [3:0]        mem2proc_tag,
  output logic [1:0]        proc2mem_command,
  output logic [XLEN-1:0]   proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  output logic [3:0]        Imem2proc_response,
  output logic [DATA_W-1:0] Imem2proc_data,
  output logic [3:0]        Imem2proc_tag,
  output logic [3:0]        Dmem2proc_response,
  output logic [DATA_W-1:0] Dmem2proc_data,
  output logic [3:0]        Dmem2proc_tag,
  output logic              Dcache_on_bus,
  output logic              tag_conflict
);

  localparam logic [1:0] BUS_NONE   = 2'd0;
  localparam logic [1:0] BUS_LOAD   = 2'd1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == STARVE_MAX) ? v : v + 4'd1;
  endfunction

  logic [3:0]          starve_cnt;
  logic                conflict_q;
  logic [NUM_TAGS-1:0] tag_vld;
  logic [NUM_TAGS-1:0] tag_own;

  logic icache_req, dcache_req, icache_force;
  logic igrant, dgrant;
  logic ret_hit, alloc;

  assign icache_req   = (Icache2arb_command != BUS_NONE);
  assign dcache_req   = (Dcache2arb_command != BUS_NONE);
  assign icache_force = icache_req && (starve_cnt == STARVE_MAX);
  assign dgrant       = !reset && dcache_req && !icache_force;
  assign igrant       = !reset && icache_req && !dgrant;

  assign ret_hit       = !reset && (mem2proc_tag != 4'd0) && tag_vld[mem2proc_tag];
  assign alloc         = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
  assign Dcache_on_bus = dgrant;
  assign tag_conflict  = conflict_q && !reset;

  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = 4'd0;
    Dmem2proc_response = 4'd0;
    Imem2proc_tag      = 4'd0;
    Imem2proc_data     = '0;
    Dmem2proc_tag      = 4'd0;
    Dmem2proc_data     = '0;
    if (dgrant) begin
      proc2mem_command   = Dcache2arb_command;
      proc2mem_addr      = Dcache2arb_addr;
      proc2mem_data      = Dcache2arb_data;
      Dmem2proc_response = mem2proc_response;
    end else if (igrant) begin
      proc2mem_command   = Icache2arb_command;
      proc2mem_addr      = Icache2arb_addr;
      Imem2proc_response = mem2proc_response;
    end
    // Return data follows the recorded owner, never the current grant
    if (ret_hit) begin
      if (tag_own[mem2proc_tag]) begin
        Dmem2proc_tag  = mem2proc_tag;
        Dmem2proc_data = mem2proc_data;
      end else begin
        Imem2proc_tag  = mem2proc_tag;
        Imem2proc_data = mem2proc_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      conflict_q <= 1'b0;
      tag_vld    <= '0;
    end else begin
      if (!icache_req || igrant)
        starve_cnt <= 4'd0;
      else if (dgrant)
        starve_cnt <= sat_inc(starve_cnt);
      if (ret_hit)
        tag_vld[mem2proc_tag] <= 1'b0;
      // A same-cycle return of this tag frees it first, so that is not a conflict
      if (alloc) begin
        tag_vld[mem2proc_response] <= 1'b1;
        if (tag_vld[mem2proc_response] && !(ret_hit && (mem2proc_tag == mem2proc_response)))
          conflict_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc)
      tag_own[mem2proc_response] <= dgrant;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: each cycle's expected outputs are queued
// with the stimulus and compared against the DUT mid-cycle.
module tb_mem_bus_arbiter;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icmd, dcmd;
  logic [31:0] iaddr, daddr;
  logic [63:0] ddat, mdata;
  logic [3:0]  resp, mtag;
  logic [1:0]  p_cmd;
  logic [31:0] p_addr;
  logic [63:0] p_data, i_data, d_data;
  logic [3:0]  i_resp, i_tag, d_resp, d_tag;
  logic        dob, conf;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       name;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  iresp, itag, dresp, dtag;
    logic [63:0] idata, ddata;
    logic        dob, conf;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16), .XLEN(32), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .Icache2arb_command(icmd), .Icache2arb_addr(iaddr),
    .Dcache2arb_command(dcmd), .Dcache2arb_addr(daddr), .Dcache2arb_data(ddat),
    .mem2proc_response(resp), .mem2proc_data(mdata), .mem2proc_tag(mtag),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .Imem2proc_response(i_resp), .Imem2proc_data(i_data), .Imem2proc_tag(i_tag),
    .Dmem2proc_response(d_resp), .Dmem2proc_data(d_data), .Dmem2proc_tag(d_tag),
    .Dcache_on_bus(dob), .tag_conflict(conf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic idle();
    icmd = BUS_NONE; iaddr = '0; dcmd = BUS_NONE; daddr = '0; ddat = '0;
    resp = '0; mdata = '0; mtag = '0;
  endtask

  task automatic clr_exp(input string nm, input logic cf);
    e.name = nm; e.cmd = BUS_NONE; e.addr = '0; e.data = '0;
    e.iresp = '0; e.itag = '0; e.dresp = '0; e.dtag = '0;
    e.idata = '0; e.ddata = '0; e.dob = 1'b0; e.conf = cf;
  endtask

  // Inputs change just after the rising edge; outputs are judged on the falling edge
  task automatic tick();
    exp_t o;
    sb.push_back(e);
    @(negedge clock);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      o = sb.pop_front();
      chk({o.name, ".cmd"},   64'(p_cmd),  64'(o.cmd));
      chk({o.name, ".addr"},  64'(p_addr), 64'(o.addr));
      chk({o.name, ".data"},  p_data,      o.data);
      chk({o.name, ".iresp"}, 64'(i_resp), 64'(o.iresp));
      chk({o.name, ".itag"},  64'(i_tag),  64'(o.itag));
      chk({o.name, ".idata"}, i_data,      o.idata);
      chk({o.name, ".dresp"}, 64'(d_resp), 64'(o.dresp));
      chk({o.name, ".dtag"},  64'(d_tag),  64'(o.dtag));
      chk({o.name, ".ddata"}, d_data,      o.ddata);
      chk({o.name, ".dob"},   64'(dob),    64'(o.dob));
      chk({o.name, ".conf"},  64'(conf),   64'(o.conf));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit dg, pdg;
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    // reset with everything active: all outputs quiet
    icmd = BUS_LOAD; iaddr = 32'h40; dcmd = BUS_LOAD; daddr = 32'h80;
    resp = 4'd1; mtag = 4'd1; mdata = 64'h11;
    clr_exp("rst", 1'b0); tick();
    reset = 1'b0;

    // icache-only load, returned five cycles later
    idle(); icmd = BUS_LOAD; iaddr = 32'h100; resp = 4'd3;
    clr_exp("iload", 1'b0); e.cmd = BUS_LOAD; e.addr = 32'h100; e.iresp = 4'd3; tick();
    for (int k = 0; k < 4; k++) begin
      idle(); clr_exp($sformatf("iwait%0d", k), 1'b0); tick();
    end
    idle(); mtag = 4'd3; mdata = 64'hDEADBEEF_CAFEF00D;
    clr_exp("iret", 1'b0); e.itag = 4'd3; e.idata = 64'hDEADBEEF_CAFEF00D; tick();

    // dcache store: data driven, its tag never returns data
    idle(); dcmd = BUS_STORE; daddr = 32'h200; ddat = 64'h1234; resp = 4'd5;
    clr_exp("store", 1'b0); e.cmd = BUS_STORE; e.addr = 32'h200; e.data = 64'h1234;
    e.dresp = 4'd5; e.dob = 1'b1; tick();
    idle(); mtag = 4'd5; mdata = 64'h5555;
    clr_exp("store_ret", 1'b0); tick();

    // both request every cycle; each cycle returns the tag accepted the cycle before
    for (int k = 0; k < 10; k++) begin
      idle();
      icmd = BUS_LOAD; iaddr = 32'h300; dcmd = BUS_LOAD; daddr = 32'h400; ddat = 64'h55;
      resp = 4'(k + 1);
      mtag = (k > 0) ? 4'(k) : 4'd0;
      mdata = 64'(1000 + k);
      clr_exp($sformatf("starve%0d", k), 1'b0);
      dg = (k % 5) != 4;
      e.cmd = BUS_LOAD;
      if (dg) begin
        e.addr = 32'h400; e.data = 64'h55; e.dresp = 4'(k + 1); e.dob = 1'b1;
      end else begin
        e.addr = 32'h300; e.iresp = 4'(k + 1);
      end
      if (k > 0) begin
        pdg = ((k - 1) % 5) != 4;
        if (pdg) begin e.dtag = 4'(k); e.ddata = 64'(1000 + k); end
        else     begin e.itag = 4'(k); e.idata = 64'(1000 + k); end
      end
      tick();
    end
    idle(); mtag = 4'd10; mdata = 64'hAA;
    clr_exp("starve_last", 1'b0); e.itag = 4'd10; e.idata = 64'hAA; tick();

    // tag 7 returned to icache while re-accepted for dcache in the same cycle
    idle(); icmd = BUS_LOAD; iaddr = 32'h700; resp = 4'd7;
    clr_exp("t7_ialloc", 1'b0); e.cmd = BUS_LOAD; e.addr = 32'h700; e.iresp = 4'd7; tick();
    idle(); dcmd = BUS_LOAD; daddr = 32'h780; resp = 4'd7; mtag = 4'd7; mdata = 64'h77;
    clr_exp("t7_swap", 1'b0); e.cmd = BUS_LOAD; e.addr = 32'h780; e.dresp = 4'd7;
    e.dob = 1'b1; e.itag = 4'd7; e.idata = 64'h77; tick();
    idle(); mtag = 4'd7; mdata = 64'h88;
    clr_exp("t7_dret", 1'b0); e.dtag = 4'd7; e.ddata = 64'h88; tick();

    // reallocating a live tag raises the sticky conflict flag
    idle(); icmd = BUS_LOAD; iaddr = 32'h900; resp = 4'd9;
    clr_exp("cf_a", 1'b0); e.cmd = BUS_LOAD; e.addr = 32'h900; e.iresp = 4'd9; tick();
    idle(); dcmd = BUS_LOAD; daddr = 32'h980; resp = 4'd9;
    clr_exp("cf_b", 1'b0); e.cmd = BUS_LOAD; e.addr = 32'h980; e.dresp = 4'd9; e.dob = 1'b1; tick();
    idle(); clr_exp("cf_set", 1'b1); tick();

    // icache not accepted, then retried and accepted
    idle(); icmd = BUS_LOAD; iaddr = 32'h600; resp = 4'd0;
    clr_exp("retry0", 1'b1); e.cmd = BUS_LOAD; e.addr = 32'h600; tick();
    idle(); icmd = BUS_LOAD; iaddr = 32'h600; resp = 4'd4;
    clr_exp("retry1", 1'b1); e.cmd = BUS_LOAD; e.addr = 32'h600; e.iresp = 4'd4; tick();
    idle(); mtag = 4'd4; mdata = 64'h4444;
    clr_exp("retry_ret", 1'b1); e.itag = 4'd4; e.idata = 64'h4444; tick();

    // reset with loads outstanding drops their later returns
    idle(); dcmd = BUS_LOAD; daddr = 32'h800; resp = 4'd2;
    clr_exp("r_alloc", 1'b1); e.cmd = BUS_LOAD; e.addr = 32'h800; e.dresp = 4'd2; e.dob = 1'b1; tick();
    reset = 1'b1;
    idle(); icmd = BUS_LOAD; iaddr = 32'h10; dcmd = BUS_LOAD; daddr = 32'h20; ddat = 64'h99;
    resp = 4'd2; mtag = 4'd9; mdata = 64'h9999;
    clr_exp("r_during", 1'b0); tick();
    reset = 1'b0;
    idle(); mtag = 4'd2; mdata = 64'h2222;
    clr_exp("r_drop2", 1'b0); tick();
    idle(); mtag = 4'd9; mdata = 64'h9999;
    clr_exp("r_drop9", 1'b0); tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory port between the instruction cache and the data cache. Each cycle it grants the bus to one requester and drives the command, address and data onto memory. It records which requester owns each outstanding memory tag and routes every returning data beat only to that owner. It also drives the Dcache_on_bus indication the icache uses to hold its miss.

Parameters:
STARVE_LIMIT, 4, max consecutive dcache grants while the icache is requesting before the icache is forced a grant (1..15)
NUM_TAGS, 16, memory tag space; tag 0 means "no response/no data"

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
Icache2arb_command  input  2  BUS_NONE/BUS_LOAD from icache
Icache2arb_addr  input  XLEN  icache line address (8-byte aligned)
Dcache2arb_command  input  2  BUS_NONE/BUS_LOAD/BUS_STORE from dcache
Dcache2arb_addr  input  XLEN  dcache address
Dcache2arb_data  input  64  store data
mem2proc_response  input  4  memory accept tag, 0 = not accepted
mem2proc_data  input  64  memory return data
mem2proc_tag  input  4  tag of returning data, 0 = none
proc2mem_command  output  2  command to memory
proc2mem_addr  output  XLEN  address to memory
proc2mem_data  output  64  store data to memory
Imem2proc_response  output  4  accept tag seen by icache
Imem2proc_data  output  64  data seen by icache
Imem2proc_tag  output  4  return tag seen by icache
Dmem2proc_response  output  4  accept tag seen by dcache
Dmem2proc_data  output  64  data seen by dcache
Dmem2proc_tag  output  4  return tag seen by dcache
Dcache_on_bus  output  1  dcache holds the bus this cycle
tag_conflict  output  1  sticky error: memory reused a tag still owned

Behaviour:
- Grant is combinational within the cycle. Requesting means command != BUS_NONE.
- Priority: the dcache wins if it requests, unless starve_cnt == STARVE_LIMIT and the icache requests; in that case the icache wins.
- Dcache_on_bus = dcache granted this cycle. The icache treats it as "not yours".
- Bus drive:
  - proc2mem_{command,addr,data} carry the granted requester's command/address/data.
  - proc2mem_data = Dcache2arb_data on a dcache grant, else 0.
  - With no grant: BUS_NONE, addr 0, data 0.
- starve_cnt (4-bit register):
  - Increments (saturating at STARVE_LIMIT) when the dcache is granted while the icache is requesting.
  - Cleared on any icache grant, or on any cycle the icache is not requesting.
- Accept routing:
  - mem2proc_response goes to the granted requester's *_response only; the other sees 0.
  - With no grant, both see 0.
- Owner table: NUM_TAGS entries of {valid, owner}, owner 0 = icache, 1 = dcache.
  - On a granted BUS_LOAD with mem2proc_response != 0: set entry[response] = {1, requester}.
  - BUS_STORE accepts are not entered, because no data returns.
- Return routing when mem2proc_tag != 0 and entry valid:
  - Owner gets *_tag = mem2proc_tag and *_data = mem2proc_data; the non-owner gets tag 0 and data 0.
  - Entry cleared at the clock edge.
- Return with mem2proc_tag != 0 but entry invalid: dropped. Both caches see tag 0; no state change.
- Same tag returned and re-accepted in one cycle: the clear happens first, then the new allocate. Final entry = new owner. Data still goes to the old owner.
- Allocate to an entry already valid (not being cleared that cycle): overwrite the owner and set tag_conflict (sticky until reset).
- *_data outputs are 0 whenever the corresponding *_tag output is 0.
- Reset (synchronous, any time, including with loads outstanding):
  - Clears the owner table, starve_cnt and tag_conflict.
  - Forces proc2mem_command = BUS_NONE and all *_response/*_tag outputs to 0 during the reset cycle.
  - Returns for pre-reset tags arriving afterwards are dropped.
- Latency: grant, accept and return routing are 0-cycle combinational. The table updates at the next edge.

Test Plan:
1. Icache-only load, addr 0x100 → proc2mem_command = BUS_LOAD, addr 0x100, Dcache_on_bus = 0. With response 3, Imem2proc_response = 3. Five cycles later mem2proc_tag = 3, data 0xDEADBEEF_CAFEF00D → Imem2proc_tag = 3 with that data; Dmem2proc_tag = 0.
2. Both request every cycle, memory accepts → dcache granted 4 cycles (Dcache_on_bus = 1), icache granted on the 5th, then the pattern repeats. Icache never waits more than 4 cycles.
3. Dcache BUS_STORE, addr 0x200, data 0x1234 → proc2mem_data = 0x1234. With response 5, a later mem2proc_tag = 5 is dropped (both *_tag = 0).
4. Icache owns tag 7; in the same cycle tag 7 returns and the dcache is accepted as tag 7 → data goes to the icache. A later tag-7 return goes to the dcache. tag_conflict stays 0.
5. Dcache load accepted as tag 2, reset pulsed one cycle, then mem2proc_tag = 2 → dropped. All outputs are 0/BUS_NONE during reset.
6. Accept with mem2proc_response = 0 while the icache is granted → Imem2proc_response = 0, no table entry. The icache retry next cycle is re-granted.
